// File: rtl/fp_norm_scheduler_if.sv
// Request/response and normalizer-side bus of the fp_norm_scheduler.
// The scheduler connects through the slave modport. The requesters, the response
// consumer and the normalizer together form the master side.
interface fp_norm_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]         denorm_data_o;
  logic [DATA_W-1:0]         norm_data_i;
  logic [3:0]                leading_bit_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [ID_W-1:0]           rsp_id_o;
  logic [DATA_W-1:0]         rsp_data_o;
  logic [3:0]                rsp_lead_o;
  logic                      rsp_zero_o;
  logic                      busy_o;

  modport slave (
    input  req_valid_i, req_data_i, norm_data_i, leading_bit_i, rsp_ready_i,
    output req_ready_o, denorm_data_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_lead_o,
           rsp_zero_o, busy_o
  );

  modport master (
    output req_valid_i, req_data_i, norm_data_i, leading_bit_i, rsp_ready_i,
    input  req_ready_o, denorm_data_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_lead_o,
           rsp_zero_o, busy_o
  );
endinterface

// File: rtl/fp_norm_scheduler.sv
// Round-robin scheduler that shares one normalizer between NUM_REQ requesters.
// It runs one transaction at a time: accept, wait for the normalizer latency, then respond.
module fp_norm_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NORM_LAT = 1,
  parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst_n,
  fp_norm_scheduler_if.slave bus
);

  localparam int unsigned LatW = 3;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] denorm_q, denorm_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        lead_q, lead_d;
  logic              zero_q, zero_d;
  logic              valid_q, valid_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic [ID_W-1:0]   grant_next;

  // Grant search: the first valid request at or above rr_ptr, wrapping around.
  always_comb begin
    logic [ID_W:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!grant_vld && bus.req_valid_i[idx[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[ID_W-1:0];
      end
    end
  end

  // Data of the granted requester and the pointer value that follows it.
  always_comb begin
    grant_data = bus.req_data_i[grant_idx*DATA_W +: DATA_W];
    grant_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  // Next-state and datapath updates for IDLE -> WAIT -> RESP.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lat_cnt_d = lat_cnt_q;
    denorm_d  = denorm_q;
    id_d      = id_q;
    data_d    = data_q;
    lead_d    = lead_q;
    zero_d    = zero_q;
    valid_d   = valid_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          denorm_d  = grant_data;
          id_d      = grant_idx;
          zero_d    = (grant_data == '0);
          rr_ptr_d  = grant_next;
          lat_cnt_d = LatW'(NORM_LAT);
          state_d   = StWait;
        end
      end
      StWait: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - LatW'(1);
        end else begin
          data_d  = bus.norm_data_i;
          lead_d  = bus.leading_bit_i;
          valid_d = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        // The handshake cycle returns to IDLE only; no accept happens in the same cycle.
        if (bus.rsp_ready_i) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Datapath and response registers; an in-flight transaction is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      lat_cnt_q <= '0;
      denorm_q  <= '0;
      id_q      <= '0;
      data_q    <= '0;
      lead_q    <= '0;
      zero_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lat_cnt_q <= lat_cnt_d;
      denorm_q  <= denorm_d;
      id_q      <= id_d;
      data_q    <= data_d;
      lead_q    <= lead_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
    end
  end

  // Outputs. The grant is gated by rst_n so that every output reads 0 while reset is held.
  always_comb begin
    bus.req_ready_o = '0;
    if (rst_n && state_q == StIdle && grant_vld) begin
      bus.req_ready_o = NUM_REQ'(1) << grant_idx;
    end
    bus.denorm_data_o = denorm_q;
    bus.rsp_valid_o   = valid_q;
    bus.rsp_id_o      = id_q;
    bus.rsp_data_o    = data_q;
    bus.rsp_lead_o    = lead_q;
    bus.rsp_zero_o    = zero_q;
    bus.busy_o        = (state_q != StIdle);
  end

endmodule

// File: tb/tb_fp_norm_scheduler.sv
// Directed bench for fp_norm_scheduler. Three instances use NORM_LAT values of 1, 0 and 3.
// Each instance is fed by a behavioural normalizer with the matching pipeline depth.
module tb_fp_norm_scheduler;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  fp_norm_scheduler_if #(.NUM_REQ(4), .DATA_W(16)) bus_a ();
  fp_norm_scheduler_if #(.NUM_REQ(4), .DATA_W(16)) bus_z ();
  fp_norm_scheduler_if #(.NUM_REQ(4), .DATA_W(16)) bus_t ();

  fp_norm_scheduler #(.NUM_REQ(4), .DATA_W(16), .NORM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  fp_norm_scheduler #(.NUM_REQ(4), .DATA_W(16), .NORM_LAT(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(bus_z)
  );
  fp_norm_scheduler #(.NUM_REQ(4), .DATA_W(16), .NORM_LAT(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .bus(bus_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference normalizer: shift left until the MSB is set; lead is the index of the top one.
  function automatic logic [15:0] norm_data(input logic [15:0] x);
    logic [15:0] y;
    y = x;
    for (int i = 0; i < 16; i++) if (y != 16'h0 && !y[15]) y = y << 1;
    return y;
  endfunction

  function automatic logic [3:0] norm_lead(input logic [15:0] x);
    logic [3:0] p;
    p = 4'd0;
    for (int i = 0; i < 16; i++) if (x[i]) p = 4'(i);
    return p;
  endfunction

  // Normalizer models with 1, 0 and 3 register stages.
  logic [15:0] p1_d;
  logic [3:0]  p1_l;
  logic [15:0] p3_d [3];
  logic [3:0]  p3_l [3];

  always @(posedge clk) begin
    p1_d    <= norm_data(bus_a.denorm_data_o);
    p1_l    <= norm_lead(bus_a.denorm_data_o);
    p3_d[0] <= norm_data(bus_t.denorm_data_o);
    p3_l[0] <= norm_lead(bus_t.denorm_data_o);
    p3_d[1] <= p3_d[0];
    p3_l[1] <= p3_l[0];
    p3_d[2] <= p3_d[1];
    p3_l[2] <= p3_l[1];
  end

  assign bus_a.norm_data_i   = p1_d;
  assign bus_a.leading_bit_i = p1_l;
  assign bus_z.norm_data_i   = norm_data(bus_z.denorm_data_o);
  assign bus_z.leading_bit_i = norm_lead(bus_z.denorm_data_o);
  assign bus_t.norm_data_i   = p3_d[2];
  assign bus_t.leading_bit_i = p3_l[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits until bus_a shows a response. n is the number of edges, capped at 20.
  task automatic wait_rsp_a(output int n);
    n = 0;
    while (!bus_a.rsp_valid_o && n < 20) begin
      tick();
      n++;
    end
  endtask

  int          n;
  int          ng;
  int          cyc;
  int          gidx [5];
  int          gcyc [5];
  logic [15:0] snap_data;

  initial begin
    rst_n = 1'b0;
    bus_a.req_valid_i = '0; bus_a.req_data_i = '0; bus_a.rsp_ready_i = 1'b1;
    bus_z.req_valid_i = '0; bus_z.req_data_i = '0; bus_z.rsp_ready_i = 1'b1;
    bus_t.req_valid_i = '0; bus_t.req_data_i = '0; bus_t.rsp_ready_i = 1'b1;
    bus_a.req_valid_i = 4'b0100;
    bus_a.req_data_i[32 +: 16] = 16'h1234;
    #2;
    check("rst_ready_gated", bus_a.req_ready_o, 4'b0000);
    check("rst_busy", bus_a.busy_o, 1'b0);
    check("rst_rsp_valid", bus_a.rsp_valid_o, 1'b0);
    check("rst_denorm", bus_a.denorm_data_o, 16'h0);
    bus_a.req_valid_i = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single request from req 1, NORM_LAT=1.
    bus_a.req_valid_i = 4'b0010;
    bus_a.req_data_i[16 +: 16] = 16'h6003;
    #1;
    check("single_grant", bus_a.req_ready_o, 4'b0010);
    tick();
    bus_a.req_valid_i = '0;
    check("single_ready_drop", bus_a.req_ready_o, 4'b0000);
    check("single_busy", bus_a.busy_o, 1'b1);
    check("single_denorm", bus_a.denorm_data_o, 16'h6003);
    check("single_valid_e0", bus_a.rsp_valid_o, 1'b0);
    tick();
    check("single_valid_e1", bus_a.rsp_valid_o, 1'b0);
    tick();
    check("single_valid_e2", bus_a.rsp_valid_o, 1'b1);
    check("single_id", bus_a.rsp_id_o, 2'd1);
    check("single_data", bus_a.rsp_data_o, 16'hC006);
    check("single_lead", bus_a.rsp_lead_o, 4'd14);
    check("single_zero", bus_a.rsp_zero_o, 1'b0);
    tick();
    check("single_done_valid", bus_a.rsp_valid_o, 1'b0);
    check("single_done_busy", bus_a.busy_o, 1'b0);

    // Zero input from req 3; the pointer now sits at 2.
    bus_a.req_valid_i = 4'b1000;
    bus_a.req_data_i[48 +: 16] = 16'h0000;
    #1;
    check("zero_grant", bus_a.req_ready_o, 4'b1000);
    tick();
    bus_a.req_valid_i = '0;
    wait_rsp_a(n);
    check("zero_latency", n, 2);
    check("zero_flag", bus_a.rsp_zero_o, 1'b1);
    check("zero_id", bus_a.rsp_id_o, 2'd3);
    check("zero_data", bus_a.rsp_data_o, 16'h0);
    tick();

    // Reset asserted mid-WAIT while req 2 is in flight.
    bus_a.req_valid_i = 4'b0100;
    bus_a.req_data_i[32 +: 16] = 16'h0F00;
    #1;
    check("rstw_grant", bus_a.req_ready_o, 4'b0100);
    tick();
    bus_a.req_valid_i = '0;
    check("rstw_busy_pre", bus_a.busy_o, 1'b1);
    check("rstw_denorm_pre", bus_a.denorm_data_o, 16'h0F00);
    #2 rst_n = 1'b0;
    bus_a.req_data_i = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    bus_a.req_valid_i = 4'b1111;
    #1;
    check("rstw_ready", bus_a.req_ready_o, 4'b0000);
    check("rstw_busy", bus_a.busy_o, 1'b0);
    check("rstw_denorm", bus_a.denorm_data_o, 16'h0);
    check("rstw_valid", bus_a.rsp_valid_o, 1'b0);
    check("rstw_id", bus_a.rsp_id_o, 2'd0);
    check("rstw_zero", bus_a.rsp_zero_o, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;

    // Round robin with all four requesters continuously valid.
    ng  = 0;
    cyc = 0;
    while (ng < 5 && cyc < 40) begin
      if (bus_a.req_ready_o != 4'b0000) begin
        for (int b = 0; b < 4; b++) if (bus_a.req_ready_o[b]) gidx[ng] = b;
        gcyc[ng] = cyc;
        ng++;
      end
      if (ng == 5) begin
        bus_a.req_valid_i = '0;
      end else begin
        tick();
        cyc++;
      end
    end
    check("rr_count", ng, 5);
    for (int k = 0; k < 5 && k < ng; k++) check($sformatf("rr_order%0d", k), gidx[k], k % 4);
    for (int k = 1; k < 5 && k < ng; k++) check($sformatf("rr_gap%0d", k), gcyc[k] - gcyc[k-1], 4);

    // Backpressure: hold the response for 5 cycles with other requests pending.
    bus_a.rsp_ready_i = 1'b0;
    bus_a.req_valid_i = 4'b0001;
    bus_a.req_data_i = {16'h0700, 16'h0500, 16'h0300, 16'h0001};
    #1;
    check("bp_grant", bus_a.req_ready_o, 4'b0001);
    tick();
    bus_a.req_valid_i = 4'b1111;
    wait_rsp_a(n);
    check("bp_latency", n, 2);
    check("bp_data", bus_a.rsp_data_o, 16'h8000);
    check("bp_lead", bus_a.rsp_lead_o, 4'd0);
    snap_data = bus_a.rsp_data_o;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", c), bus_a.rsp_valid_o, 1'b1);
      check($sformatf("bp_hold_data%0d", c), bus_a.rsp_data_o, 16'h8000);
      check($sformatf("bp_hold_id%0d", c), bus_a.rsp_id_o, 2'd0);
      check($sformatf("bp_hold_ready%0d", c), bus_a.req_ready_o, 4'b0000);
      check($sformatf("bp_hold_busy%0d", c), bus_a.busy_o, 1'b1);
    end
    bus_a.rsp_ready_i = 1'b1;
    tick();
    check("bp_release_valid", bus_a.rsp_valid_o, 1'b0);
    check("bp_release_grant", bus_a.req_ready_o, 4'b0010);
    tick();
    bus_a.req_valid_i = '0;
    check("bp_next_busy", bus_a.busy_o, 1'b1);
    check("bp_next_denorm", bus_a.denorm_data_o, 16'h0300);
    wait_rsp_a(n);
    check("bp_next_id", bus_a.rsp_id_o, 2'd1);
    tick();

    // Latency sweep: NORM_LAT=0 and NORM_LAT=3.
    bus_z.req_valid_i = 4'b0010;
    bus_z.req_data_i[16 +: 16] = 16'h6003;
    #1;
    check("lat0_grant", bus_z.req_ready_o, 4'b0010);
    tick();
    bus_z.req_valid_i = '0;
    n = 0;
    while (!bus_z.rsp_valid_o && n < 20) begin tick(); n++; end
    check("lat0_edges", n, 1);
    check("lat0_data", bus_z.rsp_data_o, 16'hC006);
    check("lat0_lead", bus_z.rsp_lead_o, 4'd14);
    tick();

    bus_t.req_valid_i = 4'b0010;
    bus_t.req_data_i[16 +: 16] = 16'h6003;
    #1;
    check("lat3_grant", bus_t.req_ready_o, 4'b0010);
    tick();
    bus_t.req_valid_i = '0;
    n = 0;
    while (!bus_t.rsp_valid_o && n < 20) begin tick(); n++; end
    check("lat3_edges", n, 4);
    check("lat3_data", bus_t.rsp_data_o, 16'hC006);
    check("lat3_lead", bus_t.rsp_lead_o, 4'd14);
    check("lat3_id", bus_t.rsp_id_o, 2'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_norm_scheduler.md
# fp_norm_scheduler

Round-robin scheduler that shares one `fp_normalizer_top` instance between `NUM_REQ` requesters. It accepts one denormalized word at a time over a valid/ready handshake and drives it into the normalizer. It waits the normalizer's pipeline latency, captures the normalized word and leading-bit position, and returns them tagged with the requester ID over a valid/ready response port. It sits between the requesting datapath units and the normalizer, and owns the normalizer's input bus exclusively.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 16: data width; must equal the normalizer width.
- `NORM_LAT`, 1: clock edges from a change on `denorm_data_o` until `norm_data_i` and `leading_bit_i` are valid, 0..7.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width (derived).

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `req_valid_i`, in, `NUM_REQ`: per-requester request valid.
- `req_data_i`, in, `NUM_REQ*DATA_W`: packed request data; requester i uses `[i*DATA_W +: DATA_W]`.
- `req_ready_o`, out, `NUM_REQ`: one-hot accept (grant).
- `denorm_data_o`, out, `DATA_W`: drives the normalizer `denorm_data_i`.
- `norm_data_i`, in, `DATA_W`: from the normalizer `norm_data_o`.
- `leading_bit_i`, in, 4: from the normalizer `leading_bit_o`.
- `rsp_valid_o`, out, 1: response valid.
- `rsp_ready_i`, in, 1: response consumer ready.
- `rsp_id_o`, out, `ID_W`: index of the requester that owns the response.
- `rsp_data_o`, out, `DATA_W`: normalized data.
- `rsp_lead_o`, out, 4: leading-bit position.
- `rsp_zero_o`, out, 1: the accepted input was all zeros; `rsp_lead_o` is don't-care.
- `busy_o`, out, 1: high whenever the state is not IDLE.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - The grant is combinational: the first set bit of `req_valid_i`, searching upward from `rr_ptr` with wrap-around.
  - `req_ready_o` is the one-hot grant in IDLE and all zeros in every other state.
- **Accept edge E0** (IDLE with any valid request):
  - `denorm_data_o` loads the granted data.
  - `rsp_id_o` loads the grant index.
  - `rsp_zero_o` loads `(data == 0)`.
  - `rr_ptr` becomes (grant+1) mod `NUM_REQ`.
  - `lat_cnt` loads `NORM_LAT`.
  - Next state is WAIT.
- **WAIT:**
  - If `lat_cnt != 0`, decrement it.
  - If `lat_cnt == 0`, capture `norm_data_i` into `rsp_data_o` and `leading_bit_i` into `rsp_lead_o`, set `rsp_valid_o`, and go to RESP.
- **RESP:**
  - All `rsp_*` outputs are held stable while `rsp_valid_o && !rsp_ready_i`.
  - On an edge where `rsp_ready_i` is high: clear `rsp_valid_o` and go to IDLE.
  - No new accept happens in that same cycle.
- `denorm_data_o` holds its value from E0 until the next accept; it never glitches mid-transaction.
- Requester obligation: keep `req_valid_i[i]` and its data stable until `req_ready_o[i]` is seen. Grant is recomputed every IDLE cycle, so a request withdrawn before it is granted is simply not served.
- **Reset** (asynchronous, any state): state goes to IDLE and `rr_ptr` to 0. Any in-flight transaction is dropped with no response. Every output goes to 0: `req_ready_o`, `denorm_data_o`, `rsp_valid_o`, `rsp_id_o`, `rsp_data_o`, `rsp_lead_o`, `rsp_zero_o`, `busy_o`.

## Timing
- Accept edge E0 to `rsp_valid_o` high: `NORM_LAT`+1 edges (default: 2 cycles).
- Minimum spacing between accepts, with `rsp_ready_i` held high: `NORM_LAT`+3 cycles (IDLE, `NORM_LAT`+1 WAIT cycles, RESP).
- `req_ready_o` can assert in the first IDLE cycle after reset deassertion, or after the RESP handshake.
- Fairness: with all requesters continuously valid, grants go 0,1,…,`NUM_REQ`-1,0,… A requester waits at most `NUM_REQ`-1 other transactions.
- Only one transaction is ever in flight. The normalizer input changes only at accept edges.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WAIT → all outputs 0 immediately. After release, the first grant goes to req 0, even if a transaction to req 2 had been in flight.
- **Single request:** req 1 sends 16'h6003 with `NORM_LAT`=1, using a model normalizer → `req_ready_o`=4'b0010 for one cycle. `rsp_valid_o` rises 2 edges later with `rsp_id_o`=1, `rsp_data_o`=16'hC006, `rsp_lead_o`=14, `rsp_zero_o`=0.
- **Round robin:** all 4 requesters valid continuously → grant order 0,1,2,3,0. Accepts spaced exactly 4 cycles apart with `rsp_ready_i`=1.
- **Backpressure:** `rsp_ready_i`=0 for 5 cycles → `rsp_*` outputs stable, `req_ready_o`=0, `busy_o`=1. On the `rsp_ready_i` edge, the next grant occurs one cycle later.
- **Zero input:** req 3 sends 16'h0000 → response has `rsp_zero_o`=1, `rsp_id_o`=3, `rsp_data_o`=0.
- **Latency sweep:** repeat the single-request case for `NORM_LAT`=0 and 3 → `rsp_valid_o` rises 1 and 4 edges after accept, respectively.
